wb_user_slave_mux: RTL and testbench
====================================

# wb_user_slave_mux

Wishbone slave-side controller for the user project area. It sits between the management SoC Wishbone port and up to `NUM_SLV` user peripherals (UART, accelerators, etc.). It decodes the user address window, forwards one transaction at a time to the selected peripheral, and returns a single registered `wbs_ack_o`. A bus-timeout engine prevents a hung peripheral from stalling the management core.

## Interface
Parameters:
- `NUM_SLV`, 4: number of downstream peripherals (1..8).
- `BASE_ADDR`, 32'h3000_0000: base of the user window.
- `SPAN_W`, 8: log2 of bytes per peripheral slot (256 B each).
- `TIMEOUT`, 255: cycles to wait for a peripheral ack before an error response.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on an error response.

Ports (clock and reset first):
- `wb_clk_i` in 1: single clock.
- `wb_rst_ni` in 1: reset, asynchronous, active-low.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1 each: upstream Wishbone controls.
- `wbs_sel_i` in 4: byte selects.
- `wbs_dat_i` in 32: write data.
- `wbs_adr_i` in 32: byte address.
- `wbs_ack_o` out 1: registered ack.
- `wbs_dat_o` out 32: registered read data.
- `slv_valid_o` out NUM_SLV: one-hot request to a peripheral.
- `slv_we_o` out 1, `slv_sel_o` out 4, `slv_dat_o` out 32, `slv_adr_o` out SPAN_W: latched request fields.
- `slv_ack_i` in NUM_SLV: per-peripheral ack.
- `slv_dat_i` in 32*NUM_SLV: per-peripheral read data; slot i is bits [32i+31:32i].
- `err_irq_o` out 1: one-cycle pulse on an error response.
- `err_addr_o` out 32: address of the last errored transaction (sticky).

## Operation
- Index bits: `IDX_W = clog2(NUM_SLV)`, minimum 1. The index is `wbs_adr_i[SPAN_W +: IDX_W]`.
- Window hit: `wbs_adr_i[31:SPAN_W+IDX_W] == BASE_ADDR[31:SPAN_W+IDX_W]`.
- FSM states: IDLE, REQ, RESP.
- **IDLE:**
  - On `cyc&stb&hit` with index < NUM_SLV: latch we, sel, dat, adr[SPAN_W-1:0] and index, clear the timer, and go to REQ.
  - On `cyc&stb&hit` with index ≥ NUM_SLV: go directly to RESP with an error.
  - A non-hit request is ignored: no ack is driven.
- **REQ:**
  - `slv_valid_o[idx]` is high and all other bits are low.
  - When `slv_ack_i[idx]` is seen: capture `slv_dat_i[idx]` (writes capture 0) and go to RESP.
  - Acks from non-selected slots are ignored.
  - If `cyc` or `stb` drops: abort, go to IDLE with no ack.
- **RESP:**
  - `wbs_ack_o` = 1 for exactly one cycle with the captured data, then go to IDLE.
  - On an error, `wbs_dat_o` = ERR_DATA, `err_irq_o` pulses in the same cycle, and `err_addr_o` updates.
- `wbs_dat_o` returns to 0 in every non-RESP cycle.
- Only one transaction is outstanding at a time. A new stb is not sampled while in REQ or RESP.

## Timing
- Every output resets to 0, including `err_addr_o`.
- Reset mid-transaction returns the FSM to IDLE immediately and asynchronously; the peripheral request is dropped.
- Latency:
  - stb sampled at edge 0; `slv_valid_o` is high after edge 0.
  - A peripheral ack in cycle k gives `wbs_ack_o` in cycle k+1.
  - Best case: `wbs_ack_o` appears in the 3rd cycle of stb, for a zero-wait peripheral.
- Timeout: the timer increments each REQ cycle. When it reaches TIMEOUT−1 without an ack, the next cycle is RESP with an error. Total REQ residency is TIMEOUT cycles.
- Ack and timeout in the same cycle: the ack wins and no error is raised.

## Configuration
- `WB_TIMEOUT_EN` defined: timer, timeout error response, `err_irq_o` and `err_addr_o` for timeouts are all present.
- Not defined:
  - REQ waits indefinitely for an ack.
  - `err_irq_o` and `err_addr_o` are only driven by the out-of-range-index error.
  - The timer logic is not compiled.

## Structure
- Package `wb_user_pkg` holds:
  - the state enum (IDLE/REQ/RESP);
  - the ERR_DATA default;
  - a clog2-based `idx_w(n)` function.
- One sub-module, `wb_timeout_cnt`: a clear/enable counter with a `expired_o` flag, instantiated only under `WB_TIMEOUT_EN`.

## Test plan
- Write 0x1234_5678 to 0x3000_0104, slot 1 acks after 2 cycles:
  - `slv_valid_o` = 4'b0010, `slv_adr_o` = 0x04, `slv_dat_o` = 0x1234_5678;
  - `wbs_ack_o` pulses once, 1 cycle after the slave ack.
- Read 0x3000_0000, slot 0 returns 0xA5A5_0001 with a zero-wait ack: `wbs_dat_o` = 0xA5A5_0001 with ack in the 3rd stb cycle; `wbs_dat_o` = 0 afterwards.
- Read 0x3000_0200 with no slot-2 ack, timeout enabled:
  - ack after TIMEOUT REQ cycles with data 0xDEAD_BEEF;
  - `err_irq_o` 1-cycle pulse, `err_addr_o` = 0x3000_0200.
- Access 0x3100_0000 (miss):
  - `slv_valid_o` stays 0 and no `wbs_ack_o` for 300 cycles.
- Abort and reset during REQ:
  - Drop stb during REQ → `slv_valid_o` clears next cycle, no ack.
  - Assert `wb_rst_ni` = 0 during REQ → all outputs 0 asynchronously.
  - The next request is handled normally.
- Slot 3 acks while slot 1 is selected, then slot 1 acks → only slot 1 data is returned, with a single ack.

Source files
------------

// File: rtl/wb_user_pkg.sv
// Shared types and helpers for the user-area Wishbone slave mux.
package wb_user_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  // Slot index width; a single peripheral still gets one index bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_user_slave_mux_tmo.sv
// Clear/enable counter that flags the last allowed wait cycle (used with WB_TIMEOUT_EN).
module wb_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (LIMIT <= 2) ? 1 : $clog2(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                  cnt_d = '0;
    else if (en_i && !expired_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_user_slave_mux.sv
// User-area Wishbone slave mux: window decode, one outstanding request, registered ack.
// Define WB_TIMEOUT_EN to add the peripheral-ack timeout and its error response.
module wb_user_slave_mux
  import wb_user_pkg::*;
#(
  parameter int          NUM_SLV   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          SPAN_W    = 8,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = ERR_DATA_DEF
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_dat_i,
  input  logic [31:0]           wbs_adr_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic [NUM_SLV-1:0]    slv_valid_o,
  output logic                  slv_we_o,
  output logic [3:0]            slv_sel_o,
  output logic [31:0]           slv_dat_o,
  output logic [SPAN_W-1:0]     slv_adr_o,
  input  logic [NUM_SLV-1:0]    slv_ack_i,
  input  logic [32*NUM_SLV-1:0] slv_dat_i,
  output logic                  err_irq_o,
  output logic [31:0]           err_addr_o
);

  localparam int IDX_W  = idx_w(NUM_SLV);
  localparam int HI_LSB = SPAN_W + IDX_W;

  if (NUM_SLV < 1 || NUM_SLV > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("wb_user_slave_mux: unsupported NUM_SLV/TIMEOUT");
  end

  wb_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [31:0]       wdat_q;
  logic [SPAN_W-1:0] adr_q;
  logic              ack_q, irq_q;
  logic [31:0]       rdat_q, eaddr_q;

  logic             req_v, hit, idx_ok, sel_ack, tmo;
  logic [IDX_W-1:0] idx_in;
  logic [31:0]      sel_dat, err_src;
  logic             start, go_resp, resp_err;
  logic [31:0]      resp_dat;

  assign req_v   = wbs_cyc_i & wbs_stb_i;
  assign hit     = (wbs_adr_i[31:HI_LSB] == BASE_ADDR[31:HI_LSB]);
  assign idx_in  = wbs_adr_i[SPAN_W +: IDX_W];
  assign idx_ok  = (int'(idx_in) < NUM_SLV);
  assign sel_ack = slv_ack_i[idx_q];
  assign sel_dat = slv_dat_i[{idx_q, 5'd0} +: 32];

`ifdef WB_TIMEOUT_EN
  logic [31:0] fadr_q;

  wb_timeout_cnt #(.LIMIT(TIMEOUT)) u_tmo (
    .clk_i    (wb_clk_i),
    .rst_ni   (wb_rst_ni),
    .clr_i    (start),
    .en_i     (state_q == ST_REQ),
    .expired_o(tmo)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)  fadr_q <= '0;
    else if (start)  fadr_q <= wbs_adr_i;
  end

  // A timeout reports the latched address; an index miss reports the live one.
  assign err_src = (state_q == ST_IDLE) ? wbs_adr_i : fadr_q;
`else
  assign tmo     = 1'b0;
  assign err_src = wbs_adr_i;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    go_resp  = 1'b0;
    resp_err = 1'b0;
    resp_dat = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_v && hit) begin
          if (idx_ok) begin
            start   = 1'b1;
            state_d = ST_REQ;
          end else begin
            go_resp  = 1'b1;
            resp_err = 1'b1;
            resp_dat = ERR_DATA;
            state_d  = ST_RESP;
          end
        end
      end
      ST_REQ: begin
        // Ack is checked before the timer so a last-cycle ack is not an error.
        if (!req_v) begin
          state_d = ST_IDLE;
        end else if (sel_ack) begin
          go_resp  = 1'b1;
          resp_dat = we_q ? 32'd0 : sel_dat;
          state_d  = ST_RESP;
        end else if (tmo) begin
          go_resp  = 1'b1;
          resp_err = 1'b1;
          resp_dat = ERR_DATA;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    slv_valid_o = '0;
    for (int i = 0; i < NUM_SLV; i++)
      slv_valid_o[i] = (state_q == ST_REQ) && (idx_q == IDX_W'(i));
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      idx_q  <= '0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      wdat_q <= '0;
      adr_q  <= '0;
    end else if (start) begin
      idx_q  <= idx_in;
      we_q   <= wbs_we_i;
      sel_q  <= wbs_sel_i;
      wdat_q <= wbs_dat_i;
      adr_q  <= wbs_adr_i[SPAN_W-1:0];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q   <= 1'b0;
      rdat_q  <= '0;
      irq_q   <= 1'b0;
      eaddr_q <= '0;
    end else begin
      ack_q  <= go_resp;
      rdat_q <= resp_dat;
      irq_q  <= go_resp & resp_err;
      if (go_resp && resp_err) eaddr_q <= err_src;
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = rdat_q;
  assign err_irq_o  = irq_q;
  assign err_addr_o = eaddr_q;
  assign slv_we_o   = we_q;
  assign slv_sel_o  = sel_q;
  assign slv_dat_o  = wdat_q;
  assign slv_adr_o  = adr_q;

endmodule

// File: tb/tb_wb_user_slave_mux.sv
// Self-checking bench for wb_user_slave_mux: vector table plus hand-written corner cases.
module tb_wb_user_slave_mux;

  localparam int TMO = 20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cyc, stb, we;
  logic [3:0]   sel;
  logic [31:0]  wdat, adr;
  logic         ack;
  logic [31:0]  rdat;
  logic [3:0]   valid;
  logic         swe;
  logic [3:0]   ssel;
  logic [31:0]  sdat;
  logic [7:0]   sadr;
  logic [3:0]   sack;
  logic [127:0] sdat_i;
  logic         irq;
  logic [31:0]  eaddr;

  always #5 clk = ~clk;

  wb_user_slave_mux #(.TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(wdat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .slv_valid_o(valid), .slv_we_o(swe), .slv_sel_o(ssel), .slv_dat_o(sdat),
    .slv_adr_o(sadr), .slv_ack_i(sack), .slv_dat_i(sdat_i),
    .err_irq_o(irq), .err_addr_o(eaddr)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    int          dly;
    logic [31:0] rdat;
    logic [3:0]  exp_valid;
    logic [31:0] exp_rdat;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] sb_q[$];
  int          n_chk = 0, n_fail = 0;
  int          ack_total = 0;

  always @(negedge clk) if (ack === 1'b1) ack_total++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pop_chk();
    n_chk++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected_ack: got data %h with no pending request", rdat);
    end else begin
      logic [31:0] e;
      n_chk--;
      e = sb_q.pop_front();
      chk("sb_rdata", rdat, e);
    end
  endtask

  task automatic start_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    @(negedge clk);
    we = w; adr = a; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
  endtask

  task automatic end_req();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // Called at a negedge after a slave ack was driven; clears it and waits for the upstream ack.
  task automatic wait_ack(input int budget, output int ncyc);
    logic got;
    got = 1'b0; ncyc = 0;
    while (ncyc < budget && !got) begin
      @(negedge clk);
      ncyc++;
      sack = '0;
      if (ack === 1'b1) begin
        got = 1'b1;
        pop_chk();
        end_req();
      end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL ack_timeout: got no ack in %0d cycles, expected one", budget);
      end_req();
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int slot, n;
    slot = int'(v.adr[9:8]);
    start_req(v.we, v.adr, v.wdat, v.sel);
    sb_q.push_back(v.exp_rdat);
    @(negedge clk);
    chk($sformatf("v%0d_valid", id), 32'(valid), 32'(v.exp_valid));
    chk($sformatf("v%0d_sadr", id), 32'(sadr), 32'(v.adr[7:0]));
    chk($sformatf("v%0d_sdat", id), sdat, v.wdat);
    chk($sformatf("v%0d_swe", id), 32'(swe), 32'(v.we));
    chk($sformatf("v%0d_ssel", id), 32'(ssel), 32'(v.sel));
    repeat (v.dly) begin
      @(negedge clk);
      chk($sformatf("v%0d_noack_wait", id), 32'(ack), 32'd0);
    end
    sack[slot] = 1'b1;
    sdat_i[32*slot +: 32] = v.rdat;
    wait_ack(5, n);
    chk($sformatf("v%0d_ack_lat", id), 32'(n), 32'd1);
    chk($sformatf("v%0d_irq", id), 32'(irq), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_ack_single", id), 32'(ack), 32'd0);
    chk($sformatf("v%0d_dat_idle", id), rdat, 32'd0);
    chk($sformatf("v%0d_valid_idle", id), 32'(valid), 32'd0);
  endtask

  initial begin
    int a0, n, bad;
    vecs[0] = '{1'b1, 32'h3000_0104, 32'h1234_5678, 4'hF, 2, 32'h0BAD_0BAD, 4'b0010, 32'h0};
    vecs[1] = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 0, 32'hA5A5_0001, 4'b0001, 32'hA5A5_0001};
    vecs[2] = '{1'b0, 32'h3000_0308, 32'h0,         4'hF, 1, 32'hCAFE_0003, 4'b1000, 32'hCAFE_0003};
    vecs[3] = '{1'b1, 32'h3000_02FC, 32'h5555_AAAA, 4'h3, 0, 32'h7777_7777, 4'b0100, 32'h0};
    vecs[4] = '{1'b0, 32'h3000_0110, 32'h0,         4'hF, 5, 32'h0101_F00D, 4'b0010, 32'h0101_F00D};

    rst_n = 1'b0; cyc = 0; stb = 0; we = 0; sel = '0; wdat = '0; adr = '0;
    sack = '0; sdat_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdat", rdat, 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_eaddr", eaddr, 32'd0);
    chk("rst_slv_fields", {swe, ssel, sadr, 19'd0}, 32'd0);
    chk("rst_sdat", sdat, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Unacknowledged request to slot 2.
    start_req(1'b0, 32'h3000_0200, 32'h0, 4'hF);
`ifdef WB_TIMEOUT_EN
    sb_q.push_back(32'hDEAD_BEEF);
    n = 0; bad = 1;
    for (int c = 0; c < 400 && bad == 1; c++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        bad = 0;
        pop_chk();
        chk("tmo_irq", 32'(irq), 32'd1);
        chk("tmo_eaddr", eaddr, 32'h3000_0200);
        end_req();
      end else if (valid == 4'b0100) n++;
    end
    chk("tmo_no_ack_seen", 32'(bad), 32'd0);
    chk("tmo_req_cycles", 32'(n), 32'(TMO));
    @(negedge clk);
    chk("tmo_irq_pulse", 32'(irq), 32'd0);
    chk("tmo_eaddr_sticky", eaddr, 32'h3000_0200);
    chk("tmo_dat_idle", rdat, 32'd0);
`else
    a0 = ack_total;
    repeat (300) @(negedge clk);
    chk("noTmo_no_ack", 32'(ack_total - a0), 32'd0);
    chk("noTmo_valid_held", 32'(valid), 32'b0100);
    chk("noTmo_irq", 32'(irq), 32'd0);
    end_req();
    @(negedge clk);
    chk("noTmo_abort_valid", 32'(valid), 32'd0);
`endif

    // Window miss.
    a0 = ack_total; bad = 0;
    start_req(1'b0, 32'h3100_0000, 32'h0, 4'hF);
    repeat (300) begin
      @(negedge clk);
      if (valid != 4'd0) bad++;
    end
    chk("miss_valid_cycles", 32'(bad), 32'd0);
    chk("miss_no_ack", 32'(ack_total - a0), 32'd0);
    end_req();

    // Abort by dropping stb during REQ.
    start_req(1'b0, 32'h3000_0100, 32'h0, 4'hF);
    @(negedge clk);
    chk("abort_valid_req", 32'(valid), 32'b0010);
    a0 = ack_total;
    end_req();
    @(negedge clk);
    chk("abort_valid_clr", 32'(valid), 32'd0);
    repeat (5) @(negedge clk);
    chk("abort_no_ack", 32'(ack_total - a0), 32'd0);

    // Asynchronous reset mid-REQ.
    start_req(1'b1, 32'h3000_0220, 32'hFEED_F00D, 4'hC);
    @(negedge clk);
    chk("rstreq_valid", 32'(valid), 32'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("rstreq_valid_clr", 32'(valid), 32'd0);
    chk("rstreq_fields", {swe, ssel, sadr, 19'd0}, 32'd0);
    chk("rstreq_sdat", sdat, 32'd0);
    chk("rstreq_ack_dat", {31'd0, ack} | rdat, 32'd0);
    chk("rstreq_eaddr", eaddr, 32'd0);
    end_req();
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[1], 5);

    // Stray ack from slot 3 while slot 1 is selected.
    start_req(1'b0, 32'h3000_0100, 32'h0, 4'hF);
    sb_q.push_back(32'h1111_1111);
    a0 = ack_total;
    @(negedge clk);
    sack[3] = 1'b1; sdat_i[96 +: 32] = 32'h3333_3333;
    @(negedge clk);
    sack = '0;
    chk("stray_valid", 32'(valid), 32'b0010);
    chk("stray_no_ack", 32'(ack), 32'd0);
    sack[1] = 1'b1; sdat_i[32 +: 32] = 32'h1111_1111;
    wait_ack(5, n);
    chk("stray_ack_lat", 32'(n), 32'd1);
    @(negedge clk);
    chk("stray_single_ack", 32'(ack_total - a0), 32'd1);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
